serializer_n_to_1: RTL and testbench

SERIALIZER_N_TO_1 -- requirements
Module: serializer_n_to_1

---
 rtl/serializer_defs.sv | 20 ++
 rtl/serializer_lane.sv | 49 ++++
 rtl/serializer_n_to_1.sv | 139 +++++++++++++
 tb/tb_serializer_n_to_1.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serializer_defs.sv
// Shared definitions for the N:1 serializer: FSM encoding, TMDS control tokens
// and a helper for sizing the bit counter.
package serializer_defs;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // TMDS control-period tokens, indexed by {C1,C0}; usable as IDLE_WORD values
  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  function automatic int cntWidth(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serializer_lane.sv
// One serial lane: a DATA_WIDTH shift register feeding a registered output bit.
// A load puts the first bit straight onto the output so it appears the cycle after the load edge.
module serializer_lane #(
  parameter int DATA_WIDTH = 10,
  parameter int LSB_FIRST  = 1
) (
  input  logic                  serial_clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic                  i_shift,
  input  logic [DATA_WIDTH-1:0] i_word,
  output logic                  o_bit
);

  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_bit;
  logic [DATA_WIDTH-1:0] w_src;
  logic [DATA_WIDTH-1:0] w_nextShift;
  logic                  w_nextBit;

  always_comb begin
    w_src       = i_load ? i_word : r_shift;
    w_nextBit   = 1'b0;
    w_nextShift = w_src;
    if (LSB_FIRST != 0) begin
      w_nextBit   = w_src[0];
      w_nextShift = w_src >> 1;
    end else begin
      w_nextBit   = w_src[DATA_WIDTH-1];
      w_nextShift = w_src << 1;
    end
  end

  // Output is forced low whenever the lane is neither loading nor shifting (IDLE)
  always_ff @(posedge serial_clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_bit   <= 1'b0;
    end else if (i_load || i_shift) begin
      r_shift <= w_nextShift;
      r_bit   <= w_nextBit;
    end else begin
      r_bit   <= 1'b0;
    end
  end

  assign o_bit = r_bit;

endmodule

// File: rtl/serializer_n_to_1.sv
// Multi-lane N:1 serializer with a one-word holding register and valid/ready handshake.
// Words are only reloaded at a word boundary, so dropping enable never truncates a word.
module serializer_n_to_1
  import serializer_defs::*;
#(
  parameter int                    DATA_WIDTH = 10,
  parameter int                    LANES      = 3,
  parameter int                    LSB_FIRST  = 1,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = DATA_WIDTH'(TMDS_CTRL_00)
) (
  input  logic                          serial_clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [LANES*DATA_WIDTH-1:0]   parallel_data,
  input  logic                          parallel_valid,
  output logic                          parallel_ready,
  output logic [LANES-1:0]              serial_data_out,
  output logic                          word_start,
  output logic                          underflow,
  output logic [15:0]                   underflow_count
);

  localparam int                CNT_W    = cntWidth(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  state_t                        r_state;
  state_t                        w_stateNext;
  logic [CNT_W-1:0]              r_count;
  logic [LANES*DATA_WIDTH-1:0]   r_holdData;
  logic                          r_holdFull;
  logic                          r_wordStart;
  logic                          r_underflow;
  logic [15:0]                   r_underflowCount;

  logic                          w_load;
  logic                          w_shift;
  logic                          w_accept;
  logic                          w_ready;
  logic                          w_underflowLoad;
  logic [LANES*DATA_WIDTH-1:0]   w_loadWord;
  logic [LANES-1:0]              w_laneBits;

  always_ff @(posedge serial_clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_stateNext = ST_RUN;
          w_load      = 1'b1;
        end
      end
      ST_RUN: begin
        if (r_count == LAST_BIT) begin
          if (enable) begin
            w_load = 1'b1;
          end else begin
            w_stateNext = ST_IDLE;
          end
        end else begin
          w_shift = 1'b1;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge serial_clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (r_state == ST_RUN && r_count != LAST_BIT) begin
      r_count <= r_count + 1'b1;
    end else begin
      r_count <= '0;
    end
  end

  // Ready also rises on a load cycle, since the held word leaves as the new one arrives
  assign w_ready         = !r_holdFull || w_load;
  assign w_accept        = parallel_valid && w_ready;
  assign w_underflowLoad = w_load && !r_holdFull;
  assign w_loadWord      = r_holdFull ? r_holdData : {LANES{IDLE_WORD}};

  always_ff @(posedge serial_clk or posedge reset) begin
    if (reset) begin
      r_holdData <= '0;
      r_holdFull <= 1'b0;
    end else if (w_accept) begin
      r_holdData <= parallel_data;
      r_holdFull <= 1'b1;
    end else if (w_load) begin
      r_holdFull <= 1'b0;
    end
  end

  always_ff @(posedge serial_clk or posedge reset) begin
    if (reset) begin
      r_wordStart      <= 1'b0;
      r_underflow      <= 1'b0;
      r_underflowCount <= '0;
    end else begin
      r_wordStart <= w_load;
      r_underflow <= w_underflowLoad;
      if (w_underflowLoad && r_underflowCount != 16'hFFFF) begin
        r_underflowCount <= r_underflowCount + 16'd1;
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    serializer_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .LSB_FIRST  (LSB_FIRST)
    ) u_lane (
      .serial_clk (serial_clk),
      .reset      (reset),
      .i_load     (w_load),
      .i_shift    (w_shift),
      .i_word     (w_loadWord[k*DATA_WIDTH +: DATA_WIDTH]),
      .o_bit      (w_laneBits[k])
    );
  end

  assign parallel_ready  = w_ready;
  assign serial_data_out = w_laneBits;
  assign word_start      = r_wordStart;
  assign underflow       = r_underflow;
  assign underflow_count = r_underflowCount;

endmodule

// File: tb/tb_serializer_n_to_1.sv
// Directed self-checking bench for serializer_n_to_1: a default 3-lane TMDS-style
// instance plus an 8-bit, single-lane, MSB-first instance sharing the same clock.
module tb_serializer_n_to_1;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [29:0] parallelData;
  logic        parallelValid;
  logic        ready;
  logic [2:0]  sdo;
  logic        wordStart;
  logic        underflow;
  logic [15:0] ufCount;

  logic        en8;
  logic [7:0]  data8;
  logic        valid8;
  logic        ready8;
  logic [0:0]  sdo8;
  logic        ws8;
  logic        uf8;
  logic [15:0] ufc8;

  int checks   = 0;
  int failures = 0;

  // Idle token as it appears on the wire, bit j = j-th bit sent (LSB first)
  logic [9:0] idleSeq = 10'b1101010100;

  serializer_n_to_1 dut (
    .serial_clk      (clk),
    .reset           (reset),
    .enable          (enable),
    .parallel_data   (parallelData),
    .parallel_valid  (parallelValid),
    .parallel_ready  (ready),
    .serial_data_out (sdo),
    .word_start      (wordStart),
    .underflow       (underflow),
    .underflow_count (ufCount)
  );

  serializer_n_to_1 #(
    .DATA_WIDTH (8),
    .LANES      (1),
    .LSB_FIRST  (0)
  ) dut8 (
    .serial_clk      (clk),
    .reset           (reset),
    .enable          (en8),
    .parallel_data   (data8),
    .parallel_valid  (valid8),
    .parallel_ready  (ready8),
    .serial_data_out (sdo8),
    .word_start      (ws8),
    .underflow       (uf8),
    .underflow_count (ufc8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Holds reset for two cycles with all inputs quiet, releasing on a falling edge
  task automatic applyReset();
    enable        = 1'b0;
    parallelValid = 1'b0;
    en8           = 1'b0;
    valid8        = 1'b0;
    reset         = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (sdo !== 3'b000) begin failures++; $display("FAIL reset_sdo got=%b want=000", sdo); end
    checks++; if (wordStart !== 1'b0) begin failures++; $display("FAIL reset_word_start got=%b want=0", wordStart); end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL reset_underflow got=%b want=0", underflow); end
    checks++; if (ufCount !== 16'd0) begin failures++; $display("FAIL reset_uf_count got=%0d want=0", ufCount); end
    checks++; if (sdo8 !== 1'b0) begin failures++; $display("FAIL reset_sdo8 got=%b want=0", sdo8); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready_after got=%b want=1", ready); end
    checks++; if (sdo !== 3'b000) begin failures++; $display("FAIL reset_idle_sdo got=%b want=000", sdo); end
  endtask

  // Preloaded 0x2AA on every lane must come out as alternating 0,1 starting with 0
  task automatic test_pattern();
    logic [2:0] expBits;
    applyReset();
    parallelData  = {3{10'h2AA}};
    parallelValid = 1'b1;
    @(negedge clk);
    parallelValid = 1'b0;
    enable        = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      expBits = (i % 2 == 1) ? 3'b111 : 3'b000;
      checks++; if (sdo !== expBits) begin failures++; $display("FAIL pattern_bit%0d got=%b want=%b", i, sdo, expBits); end
      checks++; if (wordStart !== 1'(i == 0)) begin failures++; $display("FAIL pattern_ws%0d got=%b want=%b", i, wordStart, 1'(i == 0)); end
      checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL pattern_uf%0d got=%b want=0", i, underflow); end
      @(negedge clk);
    end
    checks++; if (sdo !== 3'b000) begin failures++; $display("FAIL pattern_idle_sdo got=%b want=000", sdo); end
    checks++; if (wordStart !== 1'b0) begin failures++; $display("FAIL pattern_idle_ws got=%b want=0", wordStart); end
  endtask

  // Three words streamed with no gap; ready only opens at the wrap while the holder is full
  task automatic test_back_to_back();
    logic [9:0] words [3];
    logic [9:0] w;
    logic [2:0] expBits;
    logic       expReady;
    int         j;
    words[0] = 10'h001;
    words[1] = 10'h3FF;
    words[2] = 10'h155;
    applyReset();
    parallelData  = {3{words[0]}};
    parallelValid = 1'b1;
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_full got=%b want=0", ready); end
    enable       = 1'b1;
    parallelData = {3{words[1]}};
    #1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_load got=%b want=1", ready); end
    @(negedge clk);
    parallelData = {3{words[2]}};
    for (int c = 0; c < 30; c++) begin
      j        = c % 10;
      w        = words[c / 10];
      expBits  = {3{w[j]}};
      expReady = (c >= 20) || (j == 9);
      checks++; if (sdo !== expBits) begin failures++; $display("FAIL b2b_bit%0d got=%b want=%b", c, sdo, expBits); end
      checks++; if (wordStart !== 1'(j == 0)) begin failures++; $display("FAIL b2b_ws%0d got=%b want=%b", c, wordStart, 1'(j == 0)); end
      checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL b2b_uf%0d got=%b want=0", c, underflow); end
      checks++; if (ready !== expReady) begin failures++; $display("FAIL b2b_ready%0d got=%b want=%b", c, ready, expReady); end
      if (c == 10) parallelValid = 1'b0;
      if (c == 20) enable = 1'b0;
      @(negedge clk);
    end
    checks++; if (sdo !== 3'b000) begin failures++; $display("FAIL b2b_idle_sdo got=%b want=000", sdo); end
    checks++; if (ufCount !== 16'd0) begin failures++; $display("FAIL b2b_uf_count got=%0d want=0", ufCount); end
  endtask

  // No data offered: the idle token goes out on every lane with an underflow pulse per word
  task automatic test_underflow();
    logic [2:0] expBits;
    int         j;
    applyReset();
    enable = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 30; c++) begin
      j       = c % 10;
      expBits = {3{idleSeq[j]}};
      checks++; if (sdo !== expBits) begin failures++; $display("FAIL uf_bit%0d got=%b want=%b", c, sdo, expBits); end
      checks++; if (underflow !== 1'(j == 0)) begin failures++; $display("FAIL uf_pulse%0d got=%b want=%b", c, underflow, 1'(j == 0)); end
      checks++; if (wordStart !== 1'(j == 0)) begin failures++; $display("FAIL uf_ws%0d got=%b want=%b", c, wordStart, 1'(j == 0)); end
      if (c == 29) enable = 1'b0;
      @(negedge clk);
    end
    checks++; if (ufCount !== 16'd3) begin failures++; $display("FAIL uf_count got=%0d want=3", ufCount); end
    checks++; if (sdo !== 3'b000) begin failures++; $display("FAIL uf_idle_sdo got=%b want=000", sdo); end
  endtask

  // Enable dropped at bit 4: the word still finishes, distinct data per lane
  task automatic test_drop_enable();
    logic [9:0] lw [3];
    logic [2:0] expBits;
    lw[0] = 10'h2D3;
    lw[1] = 10'h0F0;
    lw[2] = 10'h3C5;
    applyReset();
    parallelData  = {lw[2], lw[1], lw[0]};
    parallelValid = 1'b1;
    @(negedge clk);
    parallelValid = 1'b0;
    enable        = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      expBits = {lw[2][c], lw[1][c], lw[0][c]};
      checks++; if (sdo !== expBits) begin failures++; $display("FAIL drop_bit%0d got=%b want=%b", c, sdo, expBits); end
      if (c == 4) enable = 1'b0;
      @(negedge clk);
    end
    for (int c = 0; c < 2; c++) begin
      checks++; if (sdo !== 3'b000) begin failures++; $display("FAIL drop_idle_sdo%0d got=%b want=000", c, sdo); end
      checks++; if (wordStart !== 1'b0) begin failures++; $display("FAIL drop_idle_ws%0d got=%b want=0", c, wordStart); end
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL drop_idle_ready%0d got=%b want=1", c, ready); end
      @(negedge clk);
    end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL drop_uf got=%b want=0", underflow); end
  endtask

  // Reset asserted while bit 6 of an idle token is on the wire
  task automatic test_reset_mid();
    applyReset();
    enable = 1'b1;
    @(negedge clk);
    repeat (6) @(negedge clk);
    checks++; if (sdo !== 3'b111) begin failures++; $display("FAIL midrst_pre_sdo got=%b want=111", sdo); end
    reset = 1'b1;
    #1;
    checks++; if (sdo !== 3'b000) begin failures++; $display("FAIL midrst_sdo got=%b want=000", sdo); end
    checks++; if (wordStart !== 1'b0) begin failures++; $display("FAIL midrst_ws got=%b want=0", wordStart); end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL midrst_uf got=%b want=0", underflow); end
    checks++; if (ufCount !== 16'd0) begin failures++; $display("FAIL midrst_uf_count got=%0d want=0", ufCount); end
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b want=1", ready); end
    checks++; if (sdo !== 3'b000) begin failures++; $display("FAIL midrst_post_sdo got=%b want=000", sdo); end
    checks++; if (ufCount !== 16'd0) begin failures++; $display("FAIL midrst_post_count got=%0d want=0", ufCount); end
  endtask

  // 8-bit MSB-first lane: 0x81 then 0x0F, word_start every 8 cycles
  task automatic test_msb_first();
    logic [7:0] w;
    int         j;
    applyReset();
    data8  = 8'h81;
    valid8 = 1'b1;
    @(negedge clk);
    en8   = 1'b1;
    data8 = 8'h0F;
    @(negedge clk);
    valid8 = 1'b0;
    for (int c = 0; c < 16; c++) begin
      j = c % 8;
      w = (c < 8) ? 8'h81 : 8'h0F;
      checks++; if (sdo8[0] !== w[7-j]) begin failures++; $display("FAIL msb_bit%0d got=%b want=%b", c, sdo8[0], w[7-j]); end
      checks++; if (ws8 !== 1'(j == 0)) begin failures++; $display("FAIL msb_ws%0d got=%b want=%b", c, ws8, 1'(j == 0)); end
      checks++; if (uf8 !== 1'b0) begin failures++; $display("FAIL msb_uf%0d got=%b want=0", c, uf8); end
      if (c == 8) en8 = 1'b0;
      @(negedge clk);
    end
    checks++; if (sdo8 !== 1'b0) begin failures++; $display("FAIL msb_idle_sdo got=%b want=0", sdo8); end
  endtask

  initial begin
    reset         = 1'b1;
    enable        = 1'b0;
    parallelData  = '0;
    parallelValid = 1'b0;
    en8           = 1'b0;
    data8         = '0;
    valid8        = 1'b0;
    test_reset();
    test_pattern();
    test_back_to_back();
    test_underflow();
    test_drop_enable();
    test_reset_mid();
    test_msb_first();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
